ysyx_22040125_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the RV64 in-order core. It generates per-stage stall and flush vectors from stage busy requests, load-use hazards, EX-stage redirects and MEM-stage traps. It tracks in-flight instruction fetches so that wrong-path responses are dropped after a redirect, and it sequences trap entry through a drain FSM. It also gates the ID-stage side-effect enables whenever a bubble replaces the decoded instruction. It sits beside the datapath and drives every pipeline register's hold and bubble control.

---
 rtl/ysyx_22040125_pipe_pkg.sv | 28 ++
 rtl/ysyx_22040125_fetch_tracker.sv | 45 ++++
 rtl/ysyx_22040125_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_ysyx_22040125_hazard_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040125_pipe_pkg.sv
// Shared pipeline constants for the hazard controller: stage indices,
// trap sequencer states and default parameter values.
package ysyx_22040125_pipe_pkg;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   localparam int DEF_STAGES          = 5;
   localparam int DEF_EX_IDX          = STG_EX;
   localparam int DEF_TRAP_IDX        = STG_MEM;
   localparam int DEF_LU_BUBBLES      = 1;
   localparam int DEF_MAX_OUTSTANDING = 2;

   typedef enum logic [1:0] {
      TRAP_IDLE  = 2'd0,
      TRAP_DRAIN = 2'd1,
      TRAP_FLUSH = 2'd2
   } trap_state_e;

   // Counter width able to hold 0..max_val-1, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/ysyx_22040125_fetch_tracker.sv
// Counts in-flight instruction fetches and marks responses that belong to
// a path abandoned by a redirect or trap so the IF stage can discard them.
module ysyx_22040125_fetch_tracker
   import ysyx_22040125_pipe_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic clk,
   input  logic rst,
   input  logic issue,
   input  logic resp,
   input  logic kill,
   output logic issue_ok,
   output logic fetch_drop
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] inflight_nxt;
   logic [CNT_W-1:0] drop_cnt;
   logic             issue_acc;

   assign issue_ok     = (inflight < CNT_W'(MAX_OUTSTANDING));
   assign issue_acc    = issue & issue_ok;
   assign inflight_nxt = inflight + CNT_W'(issue_acc) - CNT_W'(resp);

   // A response in the kill cycle is itself wrong-path; inflight_nxt already
   // excludes it, so the reload covers only requests still outstanding.
   assign fetch_drop = ~rst & resp & ((drop_cnt != '0) | kill);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (kill)
            drop_cnt <= inflight_nxt;
         else if (fetch_drop && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/ysyx_22040125_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush vectors, load-use
// bubbles, EX redirects, trap drain sequencing and ID enable gating.
module ysyx_22040125_hazard_ctrl
   import ysyx_22040125_pipe_pkg::*;
#(
   parameter int STAGES          = DEF_STAGES,
   parameter int EX_IDX          = DEF_EX_IDX,
   parameter int TRAP_IDX        = DEF_TRAP_IDX,
   parameter int LU_BUBBLES      = DEF_LU_BUBBLES,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] stage_busy,
   input  logic              load_use,
   input  logic              redirect_valid,
   input  logic              trap_req,
   input  logic              mem_pending,
   input  logic              fetch_issue,
   input  logic              fetch_resp,
   input  logic              data_wen_in,
   input  logic              data_ren_in,
   input  logic              reg_wen_in,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic              pc_redirect_en,
   output logic              trap_take,
   output logic              fetch_drop,
   output logic              issue_ok,
   output logic              data_wen_out,
   output logic              data_ren_out,
   output logic              reg_wen_out
);

   localparam int LU_W = cnt_width(LU_BUBBLES);

   trap_state_e       state;
   trap_state_e       state_nxt;
   logic [LU_W-1:0]   lu_cnt;
   logic [LU_W-1:0]   lu_cnt_nxt;
   logic [STAGES-1:0] busy_or;
   logic              idle;
   logic              stall_ex;
   logic              redirect_take;
   logic              lu_active;
   logic              fetch_kill;
   logic              id_gate;

   // A busy stage freezes itself and everything upstream of it.
   always_comb begin
      busy_or = stage_busy;
      for (int k = STAGES - 2; k >= 0; k--)
         busy_or[k] = stage_busy[k] | busy_or[k+1];
   end

   assign idle     = (state == TRAP_IDLE);
   assign stall_ex = busy_or[EX_IDX];

   // Trap requests outrank redirects, and redirects outrank load-use.
   assign redirect_take = ~rst & idle & redirect_valid & ~stall_ex & ~trap_req;
   assign lu_active     = ~rst & idle & ~trap_req & ~redirect_take & ~stall_ex
                          & (load_use | (lu_cnt != '0));
   assign trap_take     = ~rst & (state == TRAP_FLUSH);
   assign fetch_kill    = redirect_take | trap_take;
   assign pc_redirect_en = redirect_take;

   always_comb begin
      stall = '0;
      flush = '0;
      if (rst) begin
         flush = '1;
      end else begin
         case (state)
            TRAP_DRAIN: stall = '1;
            TRAP_FLUSH: begin
               for (int k = 0; k < STAGES; k++)
                  if (k <= TRAP_IDX) flush[k] = 1'b1;
            end
            default: begin
               stall = busy_or;
               if (lu_active)
                  for (int k = 0; k < STAGES; k++)
                     if (k < EX_IDX) stall[k] = 1'b1;
               // A register that advances while its source holds takes a bubble.
               for (int k = 1; k < STAGES; k++)
                  flush[k] = stall[k-1] & ~stall[k];
               if (redirect_take)
                  for (int k = 1; k < STAGES; k++)
                     if (k <= EX_IDX) flush[k] = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      lu_cnt_nxt = lu_cnt;
      case (state)
         TRAP_IDLE:  if (trap_req) state_nxt = mem_pending ? TRAP_DRAIN : TRAP_FLUSH;
         TRAP_DRAIN: if (!mem_pending) state_nxt = TRAP_FLUSH;
         TRAP_FLUSH: state_nxt = TRAP_IDLE;
         default:    state_nxt = TRAP_IDLE;
      endcase
      if (trap_take || redirect_take)
         lu_cnt_nxt = '0;
      else if (lu_active)
         lu_cnt_nxt = (lu_cnt == '0) ? LU_W'(LU_BUBBLES - 1) : lu_cnt - LU_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= TRAP_IDLE;
         lu_cnt <= '0;
      end else begin
         state  <= state_nxt;
         lu_cnt <= lu_cnt_nxt;
      end
   end

   assign id_gate      = ~flush[EX_IDX] & idle & ~trap_req;
   assign data_wen_out = data_wen_in & id_gate;
   assign data_ren_out = data_ren_in & id_gate;
   assign reg_wen_out  = reg_wen_in & id_gate;

   ysyx_22040125_fetch_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .issue      (fetch_issue),
      .resp       (fetch_resp),
      .kill       (fetch_kill),
      .issue_ok   (issue_ok),
      .fetch_drop (fetch_drop)
   );

endmodule

// File: tb/tb_ysyx_22040125_hazard_ctrl.sv
// Directed scoreboard bench for the hazard controller (LU_BUBBLES = 2).
module tb_ysyx_22040125_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] stage_busy = '0;
   logic       load_use = 1'b0;
   logic       redirect_valid = 1'b0;
   logic       trap_req = 1'b0;
   logic       mem_pending = 1'b0;
   logic       fetch_issue = 1'b0;
   logic       fetch_resp = 1'b0;
   logic       data_wen_in = 1'b1;
   logic       data_ren_in = 1'b1;
   logic       reg_wen_in = 1'b1;
   logic [4:0] stall;
   logic [4:0] flush;
   logic       pc_redirect_en;
   logic       trap_take;
   logic       fetch_drop;
   logic       issue_ok;
   logic       data_wen_out;
   logic       data_ren_out;
   logic       reg_wen_out;

   int checks = 0;
   int errors = 0;

   logic [16:0] exp_q[$];
   string       name_q[$];

   localparam logic [6:0] C_RST = 7'b1000000;
   localparam logic [6:0] C_LU  = 7'b0100000;
   localparam logic [6:0] C_RV  = 7'b0010000;
   localparam logic [6:0] C_TR  = 7'b0001000;
   localparam logic [6:0] C_MP  = 7'b0000100;
   localparam logic [6:0] C_FI  = 7'b0000010;
   localparam logic [6:0] C_FR  = 7'b0000001;
   localparam logic [2:0] EN    = 3'b111;
   localparam logic [2:0] NO    = 3'b000;

   always #5 clk = ~clk;

   ysyx_22040125_hazard_ctrl #(
      .STAGES          (5),
      .EX_IDX          (2),
      .TRAP_IDX        (3),
      .LU_BUBBLES      (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stage_busy     (stage_busy),
      .load_use       (load_use),
      .redirect_valid (redirect_valid),
      .trap_req       (trap_req),
      .mem_pending    (mem_pending),
      .fetch_issue    (fetch_issue),
      .fetch_resp     (fetch_resp),
      .data_wen_in    (data_wen_in),
      .data_ren_in    (data_ren_in),
      .reg_wen_in     (reg_wen_in),
      .stall          (stall),
      .flush          (flush),
      .pc_redirect_en (pc_redirect_en),
      .trap_take      (trap_take),
      .fetch_drop     (fetch_drop),
      .issue_ok       (issue_ok),
      .data_wen_out   (data_wen_out),
      .data_ren_out   (data_ren_out),
      .reg_wen_out    (reg_wen_out)
   );

   function automatic logic [16:0] E(input logic [4:0] st, input logic [4:0] fl,
                                     input logic pr, input logic tt, input logic fd,
                                     input logic iok, input logic [2:0] en);
      return {st, fl, pr, tt, fd, iok, en};
   endfunction

   task automatic step(input string nm, input logic [4:0] busy, input logic [6:0] ctl,
                       input logic [16:0] exp);
      @(posedge clk);
      #1;
      rst            = ctl[6];
      load_use       = ctl[5];
      redirect_valid = ctl[4];
      trap_req       = ctl[3];
      mem_pending    = ctl[2];
      fetch_issue    = ctl[1];
      fetch_resp     = ctl[0];
      stage_busy     = busy;
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   // Monitor: outputs are combinational, so one vector is presented per cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [16:0] e;
         logic [16:0] got;
         string       nm;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {stall, flush, pc_redirect_en, trap_take, fetch_drop, issue_ok,
                data_wen_out, data_ren_out, reg_wen_out};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s got %b want %b (stall|flush|pc|trap|drop|iok|en)", nm, got, e);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         assert (int'(dut.u_trk.inflight) <= 2) else $error("inflight counter wrapped");
         assert (int'(dut.u_trk.drop_cnt) <= 2) else $error("drop counter wrapped");
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step("rst0",          5'b00000, C_RST, E(5'b00000, 5'b11111, 0, 0, 0, 1, NO));
      step("rst1",          5'b00000, C_RST, E(5'b00000, 5'b11111, 0, 0, 0, 1, NO));
      step("idle",          5'b00000, 7'd0,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("mem_busy_a",    5'b01000, 7'd0,  E(5'b01111, 5'b10000, 0, 0, 0, 1, EN));
      step("mem_busy_b",    5'b01000, 7'd0,  E(5'b01111, 5'b10000, 0, 0, 0, 1, EN));
      step("mem_busy_drop", 5'b00000, 7'd0,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("wb_busy",       5'b10000, 7'd0,  E(5'b11111, 5'b00000, 0, 0, 0, 1, EN));
      step("id_busy",       5'b00010, 7'd0,  E(5'b00011, 5'b00100, 0, 0, 0, 1, NO));
      step("lu_1",          5'b00000, C_LU,  E(5'b00011, 5'b00100, 0, 0, 0, 1, NO));
      step("lu_2",          5'b00000, 7'd0,  E(5'b00011, 5'b00100, 0, 0, 0, 1, NO));
      step("lu_done",       5'b00000, 7'd0,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("lu_ex_busy",    5'b00100, C_LU,  E(5'b00111, 5'b01000, 0, 0, 0, 1, EN));
      step("lu_ex_after",   5'b00000, 7'd0,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("fi_1",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("fi_2",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("redir",         5'b00000, C_RV | C_FI, E(5'b00000, 5'b00110, 1, 0, 0, 0, NO));
      step("resp_drop1",    5'b00000, C_FR,  E(5'b00000, 5'b00000, 0, 0, 1, 0, EN));
      step("fi_3",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("resp_drop2",    5'b00000, C_FR,  E(5'b00000, 5'b00000, 0, 0, 1, 0, EN));
      step("resp_pass",     5'b00000, C_FR,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("fi_4",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("redir_resp",    5'b00000, C_RV | C_FR, E(5'b00000, 5'b00110, 1, 0, 1, 1, NO));
      step("fi_5",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("redir_a",       5'b00000, C_RV,  E(5'b00000, 5'b00110, 1, 0, 0, 1, NO));
      step("redir_b",       5'b00000, C_RV,  E(5'b00000, 5'b00110, 1, 0, 0, 1, NO));
      step("resp_drop3",    5'b00000, C_FR,  E(5'b00000, 5'b00000, 0, 0, 1, 1, EN));
      step("fi_6",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("resp_pass2",    5'b00000, C_FR,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("redir_lu",      5'b00000, C_RV | C_LU, E(5'b00000, 5'b00110, 1, 0, 0, 1, NO));
      step("after_redir_lu",5'b00000, 7'd0,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("trap_req",      5'b00000, C_TR | C_MP | C_RV, E(5'b00000, 5'b00000, 0, 0, 0, 1, NO));
      step("drain_1",       5'b00000, C_MP | C_RV, E(5'b11111, 5'b00000, 0, 0, 0, 1, NO));
      step("drain_2",       5'b00000, C_MP,  E(5'b11111, 5'b00000, 0, 0, 0, 1, NO));
      step("drain_3",       5'b00000, 7'd0,  E(5'b11111, 5'b00000, 0, 0, 0, 1, NO));
      step("trap_flush",    5'b00000, C_TR | C_RV, E(5'b00000, 5'b01111, 0, 1, 0, 1, NO));
      step("redir_post_trap",5'b00000, C_RV, E(5'b00000, 5'b00110, 1, 0, 0, 1, NO));
      step("lu_3",          5'b00000, C_LU,  E(5'b00011, 5'b00100, 0, 0, 0, 1, NO));
      step("trap_over_lu",  5'b00000, C_TR,  E(5'b00000, 5'b00000, 0, 0, 0, 1, NO));
      step("trap_flush2",   5'b00000, 7'd0,  E(5'b00000, 5'b01111, 0, 1, 0, 1, NO));
      step("idle_post_trap",5'b00000, 7'd0,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("fi_7",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("redir_c",       5'b00000, C_RV,  E(5'b00000, 5'b00110, 1, 0, 0, 1, NO));
      step("trap_req2",     5'b00000, C_TR | C_MP, E(5'b00000, 5'b00000, 0, 0, 0, 1, NO));
      step("drain_4",       5'b00000, C_MP,  E(5'b11111, 5'b00000, 0, 0, 0, 1, NO));
      step("rst_drain",     5'b00000, C_RST | C_MP, E(5'b00000, 5'b11111, 0, 0, 0, 1, NO));
      step("post_rst",      5'b00000, C_MP,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("fi_8",          5'b00000, C_FI,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));
      step("resp_post_rst", 5'b00000, C_FR,  E(5'b00000, 5'b00000, 0, 0, 0, 1, EN));

      @(negedge clk);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
